// File: rtl/game_pkg.sv
// Shared types and default constants for the snake game step scheduler.
package game_pkg;

  localparam int unsigned XY_W             = 10;
  localparam int unsigned STATE_W          = 3;
  localparam int unsigned LVL_W            = 3;
  localparam int unsigned H_MAX_DEF        = 639;
  localparam int unsigned V_MAX_DEF        = 479;
  localparam int unsigned BASE_FRAMES_DEF  = 8;
  localparam int unsigned MIN_FRAMES_DEF   = 2;
  localparam int unsigned FOOD_PER_LVL_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Highest speed level: the span between base and fastest period, limited by the level width.
  function automatic int unsigned max_level(input int unsigned base_frames,
                                            input int unsigned min_frames);
    int unsigned span;
    span = base_frames - min_frames;
    return (span > 7) ? 7 : span;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the scan position reaching the last visible pixel into a single-cycle frame_end pulse.
module frame_edge_detect
  import game_pkg::*;
#(
  parameter int unsigned H_MAX = H_MAX_DEF,
  parameter int unsigned V_MAX = V_MAX_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic [XY_W-1:0] i_x,
  input  logic [XY_W-1:0] i_y,
  output logic            o_frame_end_c
);

  logic w_at_end;
  logic r_at_end;

  assign w_at_end = (i_x == XY_W'(H_MAX)) && (i_y == XY_W'(V_MAX));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_at_end <= 1'b0;
    end else begin
      r_at_end <= w_at_end;
    end
  end

  // Rising edge only, so a held end position still yields one event per frame.
  assign o_frame_end_c = w_at_end & ~r_at_end;

endmodule

// File: rtl/game_step_scheduler.sv
// Snake game sequencer: counts frames, requests a snake move every period frames,
// tracks speed level from eaten food and steers IDLE/RUN/STEP/PAUSED/OVER.
module game_step_scheduler
  import game_pkg::*;
#(
  parameter int unsigned H_MAX        = H_MAX_DEF,
  parameter int unsigned V_MAX        = V_MAX_DEF,
  parameter int unsigned BASE_FRAMES  = BASE_FRAMES_DEF,
  parameter int unsigned MIN_FRAMES   = MIN_FRAMES_DEF,
  parameter int unsigned FOOD_PER_LVL = FOOD_PER_LVL_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [XY_W-1:0]    i_x,
  input  logic [XY_W-1:0]    i_y,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_food_eaten,
  input  logic               i_step_done,
  input  logic               i_collision,
  output logic               o_step_req,
  output logic [STATE_W-1:0] o_state,
  output logic [LVL_W-1:0]   o_speed_level,
  output logic               o_overrun
);

  localparam int unsigned CNT_W   = $clog2(BASE_FRAMES + 1);
  localparam int unsigned FOOD_W  = $clog2(FOOD_PER_LVL + 1);
  localparam int unsigned LVL_MAX = max_level(BASE_FRAMES, MIN_FRAMES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_step_req;
  logic              w_step_req_nxt;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  w_frame_cnt_nxt;
  logic [FOOD_W-1:0] r_food_cnt;
  logic [FOOD_W-1:0] w_food_cnt_nxt;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              r_pause_pend;
  logic              w_pause_pend_nxt;
  logic              w_frame_end;
  logic              w_counting;
  logic              w_due;
  logic [31:0]       w_period;
  logic [CNT_W-1:0]  w_period_m1;

  frame_edge_detect #(
    .H_MAX (H_MAX),
    .V_MAX (V_MAX)
  ) u_frame_edge (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_x           (i_x),
    .i_y           (i_y),
    .o_frame_end_c (w_frame_end)
  );

  // Frames per move for the current level, floored at the fastest allowed period.
  always_comb begin
    w_period = BASE_FRAMES - 32'(r_level);
    if (w_period < MIN_FRAMES) begin
      w_period = MIN_FRAMES;
    end
    w_period_m1 = CNT_W'(w_period - 32'd1);
  end

  assign w_counting = (r_state == ST_RUN) || (r_state == ST_STEP);
  // >= rather than == so a count left above a freshly shortened period still fires.
  assign w_due      = w_frame_end && w_counting && (r_frame_cnt >= w_period_m1);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_due)        w_state_nxt = ST_STEP;
        else if (i_pause) w_state_nxt = ST_PAUSED;
      end
      ST_STEP: begin
        if (i_step_done) begin
          if (i_collision)                 w_state_nxt = ST_OVER;
          else if (r_pause_pend ^ i_pause) w_state_nxt = ST_PAUSED;
          else                             w_state_nxt = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (i_pause) w_state_nxt = ST_RUN;
      end
      ST_OVER: begin
        if (i_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_step_req_nxt   = (w_state_nxt == ST_STEP);
    w_frame_cnt_nxt  = r_frame_cnt;
    w_food_cnt_nxt   = r_food_cnt;
    w_level_nxt      = r_level;
    w_overrun_nxt    = r_overrun;
    w_pause_pend_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_frame_cnt_nxt = '0;
        if (i_start) begin
          w_food_cnt_nxt = '0;
          w_level_nxt    = '0;
          w_overrun_nxt  = 1'b0;
        end
      end
      ST_OVER: w_frame_cnt_nxt = '0;
      ST_RUN, ST_STEP: begin
        if (w_due) begin
          w_frame_cnt_nxt = '0;
          // A move came due while the previous one is still outstanding; it is dropped.
          if (r_state == ST_STEP) w_overrun_nxt = 1'b1;
        end else if (w_frame_end) begin
          w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if ((r_state == ST_STEP) && !i_step_done) begin
      w_pause_pend_nxt = r_pause_pend ^ i_pause;
    end else if ((r_state == ST_RUN) && w_due) begin
      w_pause_pend_nxt = i_pause;
    end

    if (w_counting && i_food_eaten) begin
      if (r_food_cnt == FOOD_W'(FOOD_PER_LVL - 1)) begin
        w_food_cnt_nxt = '0;
        if (r_level < LVL_W'(LVL_MAX)) w_level_nxt = r_level + LVL_W'(1);
      end else begin
        w_food_cnt_nxt = r_food_cnt + FOOD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_step_req   <= 1'b0;
      r_frame_cnt  <= '0;
      r_food_cnt   <= '0;
      r_level      <= '0;
      r_overrun    <= 1'b0;
      r_pause_pend <= 1'b0;
    end else begin
      r_step_req   <= w_step_req_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_food_cnt   <= w_food_cnt_nxt;
      r_level      <= w_level_nxt;
      r_overrun    <= w_overrun_nxt;
      r_pause_pend <= w_pause_pend_nxt;
    end
  end

  assign o_step_req    = r_step_req;
  assign o_state       = r_state;
  assign o_speed_level = r_level;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_game_step_scheduler.sv
// Directed bench for game_step_scheduler: frame pacing, pause, speed-up, overrun, game over, reset.
module tb_game_step_scheduler;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [9:0] i_x = '0;
  logic [9:0] i_y = '0;
  logic       i_start = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_food_eaten = 1'b0;
  logic       i_step_done = 1'b0;
  logic       i_collision = 1'b0;
  logic       o_step_req;
  logic [2:0] o_state;
  logic [2:0] o_speed_level;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int frame_idx = 0;
  int last_req_frame = 0;
  int spacing = 0;
  int req_age = 0;
  logic prev_req = 1'b0;
  bit auto_done = 1'b0;

  always #5 clk = ~clk;

  game_step_scheduler dut (
    .i_clock       (clk),
    .i_reset_n     (i_reset_n),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_food_eaten  (i_food_eaten),
    .i_step_done   (i_step_done),
    .i_collision   (i_collision),
    .o_step_req    (o_step_req),
    .o_state       (o_state),
    .o_speed_level (o_speed_level),
    .o_overrun     (o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: pulses last exactly one edge; request rises are counted and optionally answered.
  task automatic tick();
    @(posedge clk);
    #1;
    i_start = 1'b0; i_pause = 1'b0; i_food_eaten = 1'b0;
    i_step_done = 1'b0; i_collision = 1'b0;
    if (o_step_req && !prev_req) begin
      req_cnt++;
      spacing = frame_idx - last_req_frame;
      last_req_frame = frame_idx;
      req_age = 0;
    end
    prev_req = o_step_req;
    if (auto_done && o_step_req) begin
      req_age++;
      if (req_age == 2) begin
        i_step_done = 1'b1;
        req_age = 0;
      end
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      i_x = 10'd639; i_y = 10'd479; tick();
      i_x = 10'd0;   i_y = 10'd0;   tick();
      frame_idx++;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic food(input int n);
    for (int k = 0; k < n; k++) begin
      i_food_eaten = 1'b1;
      tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(o_state), 0);
    chk("rst_req", 32'(o_step_req), 0);
    chk("rst_level", 32'(o_speed_level), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    i_reset_n = 1'b1;
    frames(3);
    chk("idle_no_req", 32'(req_cnt), 0);
    chk("idle_state", 32'(o_state), 0);

    // Basic pacing at level 0 with done two clocks after each request
    auto_done = 1'b1;
    i_start = 1'b1; tick();
    chk("start_run", 32'(o_state), 1);
    frames(8);
    chk("t1_req1", 32'(req_cnt), 1);
    chk("t1_step", 32'(o_state), 2);
    chk("t1_req_lvl", 32'(o_step_req), 1);
    frames(8);
    idle_ticks(2);
    chk("t1_req2", 32'(req_cnt), 2);
    chk("t1_spacing", 32'(spacing), 8);
    chk("t1_run", 32'(o_state), 1);

    // Held end position counts once
    i_x = 10'd639; i_y = 10'd479;
    idle_ticks(5);
    i_x = 10'd0; i_y = 10'd0;
    tick();
    frame_idx++;
    frames(6);
    chk("t2_no_req", 32'(req_cnt), 2);
    frames(1);
    chk("t2_req", 32'(req_cnt), 3);
    idle_ticks(3);

    // Pause pending in STEP, frozen count in PAUSED
    auto_done = 1'b0;
    frames(8);
    chk("t4_req", 32'(req_cnt), 4);
    frames(3);
    chk("t4_still_step", 32'(o_state), 2);
    chk("t4_no_overrun", 32'(o_overrun), 0);
    i_pause = 1'b1; tick();
    chk("t4_pend_step", 32'(o_state), 2);
    i_step_done = 1'b1; tick();
    chk("t4_paused", 32'(o_state), 3);
    chk("t4_req_drop", 32'(o_step_req), 0);
    frames(10);
    chk("t4_paused_noreq", 32'(req_cnt), 4);
    chk("t4_paused_hold", 32'(o_state), 3);
    i_pause = 1'b1; tick();
    chk("t4_resume", 32'(o_state), 1);
    frames(4);
    chk("t4_frozen_cnt", 32'(req_cnt), 4);
    frames(1);
    chk("t4_resume_req", 32'(req_cnt), 5);
    i_pause = 1'b1; tick();
    i_pause = 1'b1; tick();
    i_step_done = 1'b1; tick();
    chk("t4_pend_cancel", 32'(o_state), 1);

    // Speed-up from eaten food
    auto_done = 1'b1;
    food(8);
    chk("t3_level2", 32'(o_speed_level), 2);
    frames(5);
    chk("t3_l2_noreq", 32'(req_cnt), 5);
    frames(1);
    chk("t3_l2_req", 32'(req_cnt), 6);
    chk("t3_l2_spacing", 32'(spacing), 6);
    idle_ticks(3);
    food(40);
    chk("t3_level_sat", 32'(o_speed_level), 6);
    frames(1);
    chk("t3_l6_noreq", 32'(req_cnt), 6);
    frames(1);
    chk("t3_l6_req", 32'(req_cnt), 7);
    idle_ticks(3);

    // Asynchronous reset mid-run, then restart at level 0
    i_reset_n = 1'b0;
    #2;
    chk("rst2_state", 32'(o_state), 0);
    chk("rst2_level", 32'(o_speed_level), 0);
    i_reset_n = 1'b1;
    i_start = 1'b1; tick();
    chk("rst2_run", 32'(o_state), 1);

    // Withheld done produces overrun without a second request
    auto_done = 1'b0;
    frames(8);
    chk("t5_req", 32'(req_cnt), 8);
    frames(7);
    chk("t5_no_overrun", 32'(o_overrun), 0);
    frames(1);
    chk("t5_overrun", 32'(o_overrun), 1);
    chk("t5_req_held", 32'(o_step_req), 1);
    chk("t5_single_req", 32'(req_cnt), 8);
    food(4);
    chk("t5_level1", 32'(o_speed_level), 1);

    // Collision ends the game; start returns to IDLE then RUN with cleared status
    i_step_done = 1'b1; i_collision = 1'b1; tick();
    chk("t6_over", 32'(o_state), 4);
    chk("t6_req_drop", 32'(o_step_req), 0);
    frames(10);
    food(4);
    i_pause = 1'b1; tick();
    chk("t6_over_noreq", 32'(req_cnt), 8);
    chk("t6_over_hold", 32'(o_state), 4);
    chk("t6_over_level", 32'(o_speed_level), 1);
    i_start = 1'b1; tick();
    chk("t6_idle", 32'(o_state), 0);
    chk("t6_idle_overrun", 32'(o_overrun), 1);
    i_start = 1'b1; tick();
    chk("t6_run", 32'(o_state), 1);
    chk("t6_level_clr", 32'(o_speed_level), 0);
    chk("t6_overrun_clr", 32'(o_overrun), 0);

    // Reset while a request is outstanding drops it immediately
    frames(8);
    chk("rst3_req_up", 32'(o_step_req), 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst3_req_async", 32'(o_step_req), 0);
    chk("rst3_state_async", 32'(o_state), 0);
    i_reset_n = 1'b1;
    tick();
    chk("rst3_idle", 32'(o_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
